// File: rtl/data_memory_arb_pkg.sv
// Shared constants for the DataMemory arbiter: FSM state codes and requester indices.
package data_memory_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int unsigned REQ_CPU    = 0;
    localparam int unsigned REQ_LOADER = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: round-robin on a tie unless fixed_prio, which favours requester 0.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic       fixed_prio,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        // last_win is the index of the previous winner, so a tie goes to the other one
        if (req == 2'b11) begin
            win = (fixed_prio || last_win) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port DataMemory between the CPU and loader ports, one 3-cycle transaction
// at a time, and traps out-of-range word addresses.
module data_memory_arbiter
    import data_memory_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH      = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               req,
    input  logic [1:0]               we,
    input  logic signed [ADDR_W-1:0] addr0,
    input  logic signed [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    output logic [1:0]               gnt,
    output logic [1:0]               done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic signed [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    output logic                     mem_write_en,
    input  logic [DATA_W-1:0]        mem_read_data
);

    localparam logic signed [ADDR_W-1:0] MAX_IDX = ADDR_W'(DEPTH - 1);

    logic [1:0]               state_q, state_d;
    logic                     last_win_q;
    logic [1:0]               win_q;
    logic                     we_q;
    logic signed [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic [DATA_W-1:0]        rdata_q;
    logic                     err_q;
    logic [1:0]               win;
    logic                     pick_loader;
    logic                     in_range;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_win   (last_win_q),
        .fixed_prio (FIXED_PRIO),
        .win        (win)
    );

    assign pick_loader = win[REQ_LOADER];
    // Sign bit clear means non-negative; the upper bound is a signed compare
    assign in_range    = !addr_q[ADDR_W-1] && (addr_q <= MAX_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_win_q <= 1'b1;
            win_q      <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req) begin
                win_q   <= win;
                we_q    <= pick_loader ? we[REQ_LOADER] : we[REQ_CPU];
                addr_q  <= pick_loader ? addr1 : addr0;
                wdata_q <= pick_loader ? wdata1 : wdata0;
            end
            if (state_q == ACCESS) begin
                rdata_q    <= (!we_q && in_range) ? mem_read_data : '0;
                err_q      <= !in_range;
                last_win_q <= win_q[REQ_LOADER];
            end
        end
    end

    assign gnt            = (state_q == ACCESS) ? win_q : 2'b00;
    assign done           = (state_q == RESP) ? win_q : 2'b00;
    assign rdata          = rdata_q;
    assign err            = err_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write_en   = (state_q == ACCESS) && we_q && in_range;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-level reference model checked every cycle, plus
// directed scenarios with literal expectations. A second fixed-priority instance runs in lockstep.
module tb_data_memory_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;
    logic signed [AW-1:0] addr0 = '0;
    logic signed [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic [DW-1:0] wdata1 = '0;

    logic [1:0] gnt_a, done_a, gnt_b, done_b;
    logic [DW-1:0] rdata_a, rdata_b, mwd_a, mwd_b, mrd_a, mrd_b;
    logic err_a, err_b, mwe_a, mwe_b;
    logic signed [AW-1:0] maddr_a, maddr_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    data_memory_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_a), .done(done_a), .rdata(rdata_a),
        .err(err_a), .mem_address(maddr_a), .mem_write_data(mwd_a), .mem_write_en(mwe_a),
        .mem_read_data(mrd_a)
    );

    data_memory_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_b), .done(done_b), .rdata(rdata_b),
        .err(err_b), .mem_address(maddr_b), .mem_write_data(mwd_b), .mem_write_en(mwe_b),
        .mem_read_data(mrd_b)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return 32'h1000_0000 + i;
    endfunction

    function automatic bit inr(logic signed [AW-1:0] a);
        return (a >= 0) && (a < DEPTH);
    endfunction

    // DataMemory stand-ins; out-of-range reads return junk the arbiter must not pass on
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    assign mrd_a = inr(maddr_a) ? mem_a[maddr_a[4:0]] : (32'hBAD0_0000 | maddr_a);
    assign mrd_b = inr(maddr_b) ? mem_b[maddr_b[4:0]] : (32'hBAD0_0000 | maddr_b);

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = init_word(i);
            mem_b[i] = init_word(i);
        end
        forever begin
            @(posedge clock);
            if (mwe_a) mem_a[maddr_a[4:0]] <= mwd_a;
            if (mwe_b) mem_b[maddr_b[4:0]] <= mwd_b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a transaction is granted, and "age" counts cycles since it was accepted
    int age, m_win, m_last;
    logic m_we, e_err;
    logic signed [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, e_rdata;
    logic [DW-1:0] ref_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        age = 0; m_last = 1; m_win = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        e_rdata = '0; e_err = 0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                age = 0; m_last = 1; m_we = 0; m_addr = '0; m_wdata = '0;
            end else if (age == 1) begin
                e_err = !inr(m_addr);
                e_rdata = (!m_we && inr(m_addr)) ? ref_mem[m_addr[4:0]] : '0;
                if (m_we && inr(m_addr)) ref_mem[m_addr[4:0]] = m_wdata;
                m_last = m_win;
                age = 2;
            end else if (age == 2) begin
                age = 0;
            end else if (req != 2'b00) begin
                m_win = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                m_we = we[m_win];
                m_addr = (m_win == 1) ? addr1 : addr0;
                m_wdata = (m_win == 1) ? wdata1 : wdata0;
                age = 1;
            end
        end
    end

    always @(negedge clock) begin
        logic [1:0] eg, ed;
        eg = (age == 1) ? (2'b01 << m_win) : 2'b00;
        ed = (age == 2) ? (2'b01 << m_win) : 2'b00;
        chk("model gnt", gnt_a, eg);
        chk("model done", done_a, ed);
        chk("model mem_write_en", mwe_a, (age == 1) && m_we && inr(m_addr));
        chk("model mem_address", maddr_a, m_addr);
        chk("model mem_write_data", mwd_a, m_wdata);
        if (age == 2) begin
            chk("model rdata", rdata_a, e_rdata);
            chk("model err", err_a, e_err);
        end
    end

    task automatic xact(input logic [1:0] r, input logic [1:0] w, input int a0, input int a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        output logic [1:0] gd, output logic [31:0] grd, output logic ge,
                        output logic sw);
        int n;
        n = 0;
        sw = 1'b0;
        @(negedge clock);
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        do begin
            @(negedge clock);
            sw |= mwe_a;
            n++;
        end while (done_a == 2'b00 && n < 10);
        if (done_a == 2'b00) begin
            n_cmp++; n_fail++;
            $display("FAIL done timeout: got no done pulse, required one within 10 cycles");
        end
        gd = done_a; grd = rdata_a; ge = err_a;
        req = 2'b00;
    endtask

    initial begin
        #250000;
        $display("FAIL global timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] gd;
        logic [31:0] grd;
        logic ge, sw;
        logic [3:0] ord;
        int n;

        #3;
        chk("reset gnt", gnt_a, 2'b00);
        chk("reset done", done_a, 2'b00);
        chk("reset rdata", rdata_a, 32'h0);
        chk("reset err", err_a, 1'b0);
        chk("reset mem_write_en", mwe_a, 1'b0);
        #9 reset_n = 1'b1;

        // 1: CPU write to word 5
        @(negedge clock);
        req = 2'b01; we = 2'b01; addr0 = 5; wdata0 = 32'hDEAD;
        @(negedge clock);
        chk("t1 gnt", gnt_a, 2'b01);
        chk("t1 mem_write_en", mwe_a, 1'b1);
        chk("t1 mem_address", maddr_a, 32'd5);
        @(negedge clock);
        chk("t1 done", done_a, 2'b01);
        chk("t1 err", err_a, 1'b0);
        req = 2'b00;

        // 2: read it back
        xact(2'b01, 2'b00, 5, 0, 32'h0, 32'h0, gd, grd, ge, sw);
        chk("t2 done", gd, 2'b01);
        chk("t2 rdata", grd, 32'hDEAD);
        chk("t2 no write", sw, 1'b0);

        // 4: loader out-of-range writes
        xact(2'b10, 2'b10, 0, 32, 32'h0, 32'h1234, gd, grd, ge, sw);
        chk("t4a done", gd, 2'b10);
        chk("t4a err", ge, 1'b1);
        chk("t4a rdata", grd, 32'h0);
        chk("t4a no write", sw, 1'b0);
        xact(2'b10, 2'b10, 0, -1, 32'h0, 32'h5678, gd, grd, ge, sw);
        chk("t4b done", gd, 2'b10);
        chk("t4b err", ge, 1'b1);
        chk("t4b rdata", grd, 32'h0);
        chk("t4b no write", sw, 1'b0);

        // 3: both requesting; loader won last, so round-robin starts with the CPU
        @(negedge clock);
        req = 2'b11; we = 2'b00; addr0 = 10; addr1 = 11;
        ord = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clock); n++; end while (done_a == 2'b00 && n < 10);
            chk("t3 done seen", |done_a, 1'b1);
            ord = {ord[2:0], done_a[1]};
            chk("t3 fixed-prio winner", done_b, 2'b01);
            if (k == 3) req = 2'b00;
        end
        chk("t3 round-robin order", ord, 4'b0101);

        // 5: reset in the middle of a write access
        @(negedge clock);
        req = 2'b01; we = 2'b01; addr0 = 7; wdata0 = 32'hCAFE;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t5 gnt", gnt_a, 2'b00);
        chk("t5 mem_write_en", mwe_a, 1'b0);
        chk("t5 done", done_a, 2'b00);
        chk("t5 rdata", rdata_a, 32'h0);
        chk("t5 err", err_a, 1'b0);
        @(negedge clock);
        req = 2'b00;
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        xact(2'b01, 2'b00, 7, 0, 32'h0, 32'h0, gd, grd, ge, sw);
        chk("t5 read after abort", grd, 32'h1000_0007);

        // 6: one-cycle request pulse
        @(negedge clock);
        req = 2'b01; we = 2'b00; addr0 = 3;
        @(negedge clock);
        req = 2'b00;
        chk("t6 gnt", gnt_a, 2'b01);
        @(negedge clock);
        chk("t6 done", done_a, 2'b01);
        chk("t6 rdata", rdata_a, 32'h1000_0003);
        @(negedge clock);
        chk("t6 idle gnt", gnt_a, 2'b00);
        chk("t6 idle done", done_a, 2'b00);

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
